// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: state encoding and defaults.
// Define UART_RX_PARITY_EN to add the even-parity PARITY state.
package uart_pkg;

    localparam int DataWidth        = 8;
    localparam int DefaultClockFreq = 50_000_000;
    localparam int DefaultBaudRate  = 115_200;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;
`endif

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
// Both flops reset to 1, the idle level of the line.
module uart_rx_sync (
    input  logic clock,
    input  logic reset,
    input  logic line,
    output logic synced
);

    logic meta;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta   <= 1'b1;
            synced <= 1'b1;
        end else begin
            meta   <= line;
            synced <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver, 8 data bits, 1 stop bit, with a one-byte holding register.
// Define UART_RX_PARITY_EN to expect one even-parity bit after bit 7.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int ClockFreq = DefaultClockFreq,
    parameter int BaudRate  = DefaultBaudRate
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 SIn,
    output logic [DataWidth-1:0] DataOut,
    output logic                 DataOutValid,
    input  logic                 DataOutReady,
    output logic                 FrameError,
    output logic                 Overrun,
    output logic                 ParityError
);

    localparam int SymbolEdgeTime = ClockFreq / BaudRate;
    localparam int HalfTime       = SymbolEdgeTime / 2;
    localparam int CntW           = $clog2(SymbolEdgeTime + 1);

    localparam logic [CntW-1:0] FullLast = CntW'(SymbolEdgeTime - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(HalfTime - 1);

    state_t                 state, state_next;
    logic [CntW-1:0]        cycle_cnt, cycle_next;
    logic [3:0]             bit_cnt, bit_next;
    logic [DataWidth-1:0]   shift, shift_next;
    logic                   parity_bad, parity_bad_next;
    logic                   sin_s, sin_prev, fall;
    logic                   complete;
    logic                   frame_err_next, parity_err_next;

    uart_rx_sync u_sync (
        .clock  (Clock),
        .reset  (Reset),
        .line   (SIn),
        .synced (sin_s)
    );

    assign fall = sin_prev && !sin_s;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            cycle_cnt  <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            parity_bad <= 1'b0;
            sin_prev   <= 1'b1;
        end else begin
            state      <= state_next;
            cycle_cnt  <= cycle_next;
            bit_cnt    <= bit_next;
            shift      <= shift_next;
            parity_bad <= parity_bad_next;
            sin_prev   <= sin_s;
        end
    end

    always_comb begin
        state_next      = state;
        cycle_next      = cycle_cnt + 1'b1;
        bit_next        = bit_cnt;
        shift_next      = shift;
        parity_bad_next = parity_bad;
        complete        = 1'b0;
        frame_err_next  = 1'b0;
        parity_err_next = 1'b0;
        case (state)
            IDLE: begin
                cycle_next = '0;
                if (fall) begin
                    state_next      = START;
                    bit_next        = '0;
                    parity_bad_next = 1'b0;
                end
            end
            START: begin
                // Mid-bit check rejects glitches shorter than half a bit
                if (cycle_cnt == HalfLast) begin
                    cycle_next = '0;
                    state_next = sin_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cycle_cnt == FullLast) begin
                    cycle_next = '0;
                    shift_next = {sin_s, shift[DataWidth-1:1]};
                    bit_next   = bit_cnt + 1'b1;
                    if (bit_cnt == 4'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cycle_cnt == FullLast) begin
                    cycle_next      = '0;
                    parity_bad_next = sin_s != (^shift);
                    state_next      = STOP;
                end
            end
`endif
            STOP: begin
                if (cycle_cnt == FullLast) begin
                    cycle_next = '0;
                    state_next = IDLE;
                    if (!sin_s) begin
                        frame_err_next = 1'b1;
                    end else if (parity_bad) begin
                        parity_err_next = 1'b1;
                    end else begin
                        complete = 1'b1;
                    end
                end
            end
            default: begin
                cycle_next = '0;
                state_next = IDLE;
            end
        endcase
    end

    // Holding register: a same-cycle handshake frees the slot for a new byte
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            DataOut      <= '0;
            DataOutValid <= 1'b0;
            FrameError   <= 1'b0;
            Overrun      <= 1'b0;
            ParityError  <= 1'b0;
        end else begin
            FrameError  <= frame_err_next;
            ParityError <= parity_err_next;
            Overrun     <= complete && DataOutValid && !DataOutReady;
            if (complete && (!DataOutValid || DataOutReady)) begin
                DataOut      <= shift;
                DataOutValid <= 1'b1;
            end else if (DataOutReady) begin
                DataOutValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 16 clocks per bit.
// Build with UART_RX_PARITY_EN defined to also cover the parity frames.
module tb_uart_receiver;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       SIn;
    logic [7:0] DataOut;
    logic       DataOutValid;
    logic       DataOutReady;
    logic       FrameError;
    logic       Overrun;
    logic       ParityError;

    int checks = 0;
    int errors = 0;
    int fe_n = 0;
    int ov_n = 0;
    int pe_n = 0;

`ifdef UART_RX_PARITY_EN
    localparam int ParBits = 1;
`else
    localparam int ParBits = 0;
`endif
    // Completion edge, counted in clocks from the start-bit negedge
    localparam int DoneEdge = 154 + 16 * ParBits;

    uart_receiver #(
        .ClockFreq (16),
        .BaudRate  (1)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .SIn          (SIn),
        .DataOut      (DataOut),
        .DataOutValid (DataOutValid),
        .DataOutReady (DataOutReady),
        .FrameError   (FrameError),
        .Overrun      (Overrun),
        .ParityError  (ParityError)
    );

    always #5 Clock = ~Clock;

    always @(negedge Clock) begin
        if (!Reset) begin
            fe_n = fe_n + int'(FrameError);
            ov_n = ov_n + int'(Overrun);
            pe_n = pe_n + int'(ParityError);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_valid;
        logic [7:0] exp_data;
        int         exp_fe;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bits(input logic [7:0] d, input logic par,
                             input logic stop);
        @(negedge Clock);
        SIn = 1'b0;
        repeat (16) @(negedge Clock);
        for (int i = 0; i < 8; i++) begin
            SIn = d[i];
            repeat (16) @(negedge Clock);
        end
        if (ParBits != 0) begin
            SIn = par;
            repeat (16) @(negedge Clock);
        end
        SIn = stop;
        repeat (16) @(negedge Clock);
        SIn = 1'b1;
        repeat (4) @(negedge Clock);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bits(d, ^d, stop);
    endtask

    task automatic consume(input string name);
        @(negedge Clock);
        DataOutReady = 1'b1;
        @(negedge Clock);
        DataOutReady = 1'b0;
        chk(name, 32'(DataOutValid), 32'd0);
    endtask

    initial begin
        int fe0, ov0, pe0;

        vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 0};
        vecs[1] = '{8'h3C, 1'b0, 1'b0, 8'hA5, 1};
        vecs[2] = '{8'h00, 1'b1, 1'b1, 8'h00, 0};
        vecs[3] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 0};
        vecs[4] = '{8'h81, 1'b0, 1'b0, 8'hFF, 1};
        vecs[5] = '{8'hC3, 1'b1, 1'b1, 8'hC3, 0};

        Reset        = 1'b1;
        SIn          = 1'b1;
        DataOutReady = 1'b0;
        repeat (3) @(negedge Clock);
        chk("rst_valid", 32'(DataOutValid), 32'd0);
        chk("rst_data", 32'(DataOut), 32'd0);
        chk("rst_pulses", {29'd0, FrameError, Overrun, ParityError}, 32'd0);
        Reset = 1'b0;
        repeat (8) @(negedge Clock);

        for (int k = 0; k < 6; k++) begin
            fe0 = fe_n; ov0 = ov_n; pe0 = pe_n;
            send_frame(vecs[k].data, vecs[k].stop);
            chk($sformatf("v%0d_valid", k), 32'(DataOutValid),
                32'(vecs[k].exp_valid));
            chk($sformatf("v%0d_data", k), 32'(DataOut),
                32'(vecs[k].exp_data));
            chk($sformatf("v%0d_fe", k), fe_n - fe0, vecs[k].exp_fe);
            chk($sformatf("v%0d_ov", k), ov_n - ov0, 0);
            chk($sformatf("v%0d_pe", k), pe_n - pe0, 0);
            if (vecs[k].exp_valid)
                consume($sformatf("v%0d_ack", k));
        end

        // Short low glitch must be rejected, then a real frame still works
        fe0 = fe_n; ov0 = ov_n; pe0 = pe_n;
        @(negedge Clock);
        SIn = 1'b0;
        repeat (3) @(negedge Clock);
        SIn = 1'b1;
        repeat (30) @(negedge Clock);
        chk("glitch_valid", 32'(DataOutValid), 32'd0);
        chk("glitch_pulses", (fe_n - fe0) + (ov_n - ov0) + (pe_n - pe0), 0);
        send_frame(8'h96, 1'b1);
        chk("after_glitch_data", 32'(DataOut), 32'h96);
        chk("after_glitch_valid", 32'(DataOutValid), 32'd1);
        consume("after_glitch_ack");

        // Overrun: second byte dropped while the first is still held
        ov0 = ov_n;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        chk("ovr_data", 32'(DataOut), 32'h11);
        chk("ovr_valid", 32'(DataOutValid), 32'd1);
        chk("ovr_pulse", ov_n - ov0, 1);

        // Handshake on the completion cycle: new byte loads, no overrun
        ov0 = ov_n;
        fork
            send_frame(8'h22, 1'b1);
            begin
                @(negedge Clock);
                repeat (DoneEdge) @(negedge Clock);
                chk("coin_pre_valid", 32'(DataOutValid), 32'd1);
                chk("coin_pre_data", 32'(DataOut), 32'h11);
                DataOutReady = 1'b1;
                @(negedge Clock);
                DataOutReady = 1'b0;
                chk("coin_valid", 32'(DataOutValid), 32'd1);
                chk("coin_data", 32'(DataOut), 32'h22);
            end
        join
        chk("coin_no_ovr", ov_n - ov0, 0);

        // Reset during bit 4 of 0xFF abandons the frame and clears outputs
        @(negedge Clock);
        SIn = 1'b0;
        repeat (16) @(negedge Clock);
        SIn = 1'b1;
        repeat (16 * 4 + 8) @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        chk("midrst_valid", 32'(DataOutValid), 32'd0);
        chk("midrst_data", 32'(DataOut), 32'd0);
        chk("midrst_pulses", {29'd0, FrameError, Overrun, ParityError}, 32'd0);
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        repeat (20) @(negedge Clock);
        fe0 = fe_n; ov0 = ov_n; pe0 = pe_n;
        send_frame(8'h5A, 1'b1);
        chk("postrst_data", 32'(DataOut), 32'h5A);
        chk("postrst_valid", 32'(DataOutValid), 32'd1);
        chk("postrst_pulses", (fe_n - fe0) + (ov_n - ov0) + (pe_n - pe0), 0);
        consume("postrst_ack");

`ifdef UART_RX_PARITY_EN
        pe0 = pe_n;
        send_bits(8'h07, 1'b0, 1'b1);
        chk("par_bad_pulse", pe_n - pe0, 1);
        chk("par_bad_valid", 32'(DataOutValid), 32'd0);
        pe0 = pe_n;
        send_bits(8'h07, 1'b1, 1'b1);
        chk("par_ok_pulse", pe_n - pe0, 0);
        chk("par_ok_valid", 32'(DataOutValid), 32'd1);
        chk("par_ok_data", 32'(DataOut), 32'h07);
        consume("par_ok_ack");
`else
        chk("par_const", pe_n, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter ClockFreq, default 50_000_000, meaning Clock frequency in Hz.
REQ-002 Parameter BaudRate, default 115_200, meaning serial bit rate; SymbolEdgeTime = ClockFreq/BaudRate cycles per bit, integer division.
REQ-003 Clock  input  1  sole clock; all state on rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 SIn  input  1  serial line from the board; idles high; asynchronous to Clock.
REQ-006 DataOut  output  8  received byte, held stable while DataOutValid is high.
REQ-007 DataOutValid  output  1  byte available in the holding register.
REQ-008 DataOutReady  input  1  consumer accepts the byte.
REQ-009 FrameError  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 Overrun  output  1  one-cycle pulse: completed byte dropped because the holding register was full.
REQ-011 ParityError  output  1  one-cycle pulse: parity mismatch; constant 0 when UART_RX_PARITY_EN is undefined.

Function
REQ-012 SIn shall pass through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-013 FSM states shall be IDLE, START, DATA, PARITY (macro only) and STOP.
REQ-014 IDLE->START on a synchronized falling edge; the bit counter clears.
REQ-015 START: at SymbolEdgeTime/2 cycles, sample; low->DATA, high->IDLE (glitch rejected, no outputs).
REQ-016 DATA: sample every SymbolEdgeTime cycles; 8 bits, LSB first, into a shift register; after bit 7->PARITY or STOP.
REQ-017 STOP: sample once; high->byte complete; low->FrameError pulse, byte discarded; either way->IDLE.
REQ-018 On completion with DataOutValid low, DataOut shall load and DataOutValid shall rise on the next cycle.
REQ-019 A DataOutValid&&DataOutReady cycle shall deassert DataOutValid next cycle unless a new byte completes the same cycle.
REQ-020 If the handshake and completion coincide, the new byte shall load, DataOutValid shall stay high and Overrun shall not pulse.
REQ-021 On completion with DataOutValid high and no handshake, the new byte shall drop, DataOut shall be unchanged and Overrun shall pulse.
REQ-022 Cycle and bit counters shall be wide enough for SymbolEdgeTime and 8 with no wrap mid-bit; the cycle counter shall clear at each sample point.

Reset
REQ-023 Reset shall force: state IDLE, counters 0, synchronizer flops 1, DataOut 0, DataOutValid 0, FrameError/Overrun/ParityError 0.
REQ-024 Reset mid-frame shall abandon the partial byte; reception resumes at the next falling edge after release.

Configuration
REQ-025 With UART_RX_PARITY_EN defined, one even-parity bit shall follow bit 7; a mismatch shall pulse ParityError and discard the byte after STOP.
REQ-026 With UART_RX_PARITY_EN undefined, the frame shall be 8N1, the PARITY state shall be absent and ParityError shall be 0.

Structure
REQ-027 Package uart_pkg shall hold the FSM state encoding, the data width (8) and the default ClockFreq/BaudRate.
REQ-028 The synchronizer shall be sub-module uart_rx_sync (2 flops, reset value 1).

Verification (ClockFreq=16, BaudRate=1 -> 16 cycles/bit)
REQ-029 Frame 0xA5, stop=1 -> DataOut=0xA5, DataOutValid high until DataOutReady; no error pulses.
REQ-030 SIn low for 3 cycles, then high -> FSM back in IDLE, DataOutValid stays 0, no pulses.
REQ-031 Frame 0x3C, stop=0 -> FrameError pulses exactly 1 cycle; DataOutValid stays 0.
REQ-032 0x11 then 0x22, DataOutReady=0 -> DataOut=0x11, Overrun pulses once; repeating with DataOutReady high on 0x22's completion cycle -> DataOut=0x22, no Overrun.
REQ-033 Reset asserted during bit 4 of 0xFF -> all outputs 0 next cycle; next frame 0x5A is received correctly.
REQ-034 Macro defined: 0x07 with parity bit 0 -> ParityError pulses, DataOutValid stays 0; with parity bit 1 -> DataOut=0x07.
